// File: rtl/fifo_serializer.sv
// Pops wide FIFO words and streams them as narrow valid/ready beats; beat 0 appears the cycle after the pop.
// Back-to-back words need no bubble; while out_valid && !out_ready the beat holds and no pop is issued.
module fifo_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int BEAT_WIDTH = 16,
  parameter int MSB_FIRST  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_front,
  input  logic                  fifo_empty,
  output logic                  fifo_remove,
  output logic [BEAT_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_CNT = BCW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  words_sent_q, words_sent_d;
  logic                  busy, last, handshake, load;

  always_comb begin
    busy         = (state_q == SEND);
    last         = busy && (beat_cnt_q == LAST_CNT);
    handshake    = busy && out_ready;
    // Refill in the same cycle the final beat leaves so words run back to back.
    load         = !reset && !fifo_empty && (!busy || (handshake && last));
    state_d      = state_q;
    shreg_d      = shreg_q;
    beat_cnt_d   = beat_cnt_q;
    words_sent_d = words_sent_q;

    if (handshake && last) begin
      words_sent_d = words_sent_q + 1'b1;
    end

    if (load) begin
      state_d    = SEND;
      shreg_d    = fifo_front;
      beat_cnt_d = '0;
    end else if (handshake) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        shreg_d    = (MSB_FIRST != 0) ? (shreg_q << BEAT_WIDTH) : (shreg_q >> BEAT_WIDTH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      beat_cnt_q   <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      beat_cnt_q   <= beat_cnt_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign fifo_remove = load;
  assign out_valid   = busy;
  assign out_last    = last;
  assign words_sent  = words_sent_q;
  assign out_data    = (MSB_FIRST != 0) ? shreg_q[DATA_WIDTH-1 -: BEAT_WIDTH]
                                        : shreg_q[BEAT_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_serializer.sv
// Two serializers (LSB-first/16-bit count, MSB-first/2-bit count) fed from identical FIFO models,
// checked every cycle against a queue of expected beats built from each popped word.
module tb_fifo_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_ready = 1'b0;
  logic [63:0] front_a, front_b;
  logic        empty_a, empty_b;
  logic        rm_a, rm_b, vld_a, vld_b, lst_a, lst_b;
  logic [15:0] dat_a, dat_b, ws_a;
  logic [1:0]  ws_b;

  logic [63:0] fq[2][$];
  logic [16:0] exp_q[2][$];
  int unsigned wcnt[2];
  bit          pop_pend[2];
  bit          prev_rst = 1'b0;
  int          checks = 0;
  int          errors = 0;

  fifo_serializer #(.DATA_WIDTH(64), .BEAT_WIDTH(16), .MSB_FIRST(0), .CNT_WIDTH(16)) u_lsb (
    .clk(clk), .reset(reset), .fifo_front(front_a), .fifo_empty(empty_a), .fifo_remove(rm_a),
    .out_data(dat_a), .out_valid(vld_a), .out_ready(out_ready), .out_last(lst_a), .words_sent(ws_a)
  );

  fifo_serializer #(.DATA_WIDTH(64), .BEAT_WIDTH(16), .MSB_FIRST(1), .CNT_WIDTH(2)) u_msb (
    .clk(clk), .reset(reset), .fifo_front(front_b), .fifo_empty(empty_b), .fifo_remove(rm_b),
    .out_data(dat_b), .out_valid(vld_b), .out_ready(out_ready), .out_last(lst_b), .words_sent(ws_b)
  );

  initial forever #5 clk = ~clk;

  function automatic void chk(input string name, input int k, input logic [63:0] act,
                              input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", name, k, $time, act, expv);
    end
  endfunction

  function automatic logic [15:0] beat_of(input logic [63:0] w, input int i, input int k);
    int s;
    s = (k == 1) ? (3 - i) : i;
    return 16'(w >> (16 * s));
  endfunction

  task automatic refresh();
    empty_a = (fq[0].size() == 0);
    empty_b = (fq[1].size() == 0);
    front_a = empty_a ? 64'h0 : fq[0][0];
    front_b = empty_b ? 64'h0 : fq[1][0];
  endtask

  task automatic push_word(input logic [63:0] w);
    fq[0].push_back(w);
    fq[1].push_back(w);
    refresh();
  endtask

  // Per-cycle monitor: n expected beats outstanding means the DUT must be presenting exp_q[0].
  task automatic mon(input int k, input logic vld, input logic lst, input logic rm,
                     input logic empty, input logic [15:0] dat, input logic [15:0] ws,
                     input int unsigned wmod);
    int   n;
    logic exp_rm;
    n = exp_q[k].size();
    if (prev_rst) begin
      chk("rst_data", k, dat, 0);
      chk("rst_last", k, lst, 0);
      chk("rst_words", k, ws, 0);
    end
    chk("valid", k, vld, n != 0);
    if (n != 0 && vld) begin
      chk("data", k, dat, exp_q[k][0][15:0]);
      chk("last", k, lst, exp_q[k][0][16]);
    end
    chk("words", k, ws, wcnt[k] % wmod);
    exp_rm = !reset && !empty && (n == 0 || (n == 1 && out_ready));
    chk("remove", k, rm, exp_rm);
    pop_pend[k] = rm && !empty;
    if (reset) begin
      exp_q[k].delete();
      wcnt[k] = 0;
    end else begin
      if (vld && out_ready && n != 0) begin
        if (exp_q[k][0][16]) wcnt[k]++;
        void'(exp_q[k].pop_front());
      end
      if (rm && !empty) begin
        for (int i = 0; i < 4; i++) exp_q[k].push_back({i == 3, beat_of(fq[k][0], i, k)});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, vld_a, lst_a, rm_a, empty_a, dat_a, ws_a, 65536);
    mon(1, vld_b, lst_b, rm_b, empty_b, dat_b, {14'h0, ws_b}, 4);
    prev_rst = reset;
  end

  // FIFO model: head advances just after the edge at which fifo_remove was seen high.
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (pop_pend[k]) begin
        void'(fq[k].pop_front());
        pop_pend[k] = 1'b0;
      end
    end
    refresh();
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles && !done; i++) begin
      next_cycle();
      done = exp_q[0].size() == 0 && exp_q[1].size() == 0 && fq[0].size() == 0 && fq[1].size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d beats pending expected 0", exp_q[0].size(), exp_q[1].size());
    end
  endtask

  task automatic wait_beats_left(input int left, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      next_cycle();
      hit = (exp_q[0].size() == left);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats pending expected %0d", name, exp_q[0].size(), left);
    end
  endtask

  initial begin
    refresh();
    push_word(64'h4444_3333_2222_1111);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    wait_drain(50);

    push_word(64'hA004_A003_A002_A001);
    push_word(64'hB004_B003_B002_B001);
    wait_drain(50);

    push_word(64'h4444_3333_2222_1111);
    wait_beats_left(3, "stall");
    out_ready = 1'b0;
    repeat (3) next_cycle();
    wait_drain(50);

    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      next_cycle();
    end

    push_word(64'h4444_3333_2222_1111);
    out_ready = 1'b1;
    wait_beats_left(2, "midword");
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    push_word(64'hDDDD_CCCC_BBBB_AAAA);
    wait_drain(50);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && fq[0].size() < 6) push_word({$urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    wait_drain(200);
    repeat (2) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
